// File: rtl/axis_fork_ctrl.sv
// Single-slot fork: one AXI4-Stream beat is copied to two consumers.
// The slot frees only after every enabled output has taken the beat.
module axis_fork_ctrl #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int ID_W   = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        cfg_enable,

    input  logic              input_axis_tvalid,
    output logic              input_axis_tready,
    input  logic [DATA_W-1:0] input_axis_tdata,
    input  logic [KEEP_W-1:0] input_axis_tkeep,
    input  logic [ID_W-1:0]   input_axis_tid,
    input  logic              input_axis_tlast,

    output logic              output1_axis_tvalid,
    input  logic              output1_axis_tready,
    output logic [DATA_W-1:0] output1_axis_tdata,
    output logic [KEEP_W-1:0] output1_axis_tkeep,
    output logic [ID_W-1:0]   output1_axis_tid,
    output logic              output1_axis_tlast,

    output logic              output2_axis_tvalid,
    input  logic              output2_axis_tready,
    output logic [DATA_W-1:0] output2_axis_tdata,
    output logic [KEEP_W-1:0] output2_axis_tkeep,
    output logic [ID_W-1:0]   output2_axis_tid,
    output logic              output2_axis_tlast,

    output logic [CNT_W-1:0]  pkt_count1,
    output logic [CNT_W-1:0]  pkt_count2,
    output logic              busy
);

    logic              full;
    logic [1:0]        pend;
    logic [1:0]        mask;
    logic              in_pkt;
    logic [DATA_W-1:0] hold_data;
    logic [KEEP_W-1:0] hold_keep;
    logic [ID_W-1:0]   hold_id;
    logic              hold_last;

    logic [1:0]        hs;
    logic [1:0]        eff;
    logic              free_now;
    logic              in_hs;
    logic              load;

    assign output1_axis_tvalid = full && pend[0];
    assign output2_axis_tvalid = full && pend[1];

    assign hs = {output2_axis_tvalid && output2_axis_tready,
                 output1_axis_tvalid && output1_axis_tready};

    // The slot counts as free in the cycle its last owed handshake lands,
    // which lets a new beat load with no bubble.
    assign free_now = !full || ((pend & ~hs) == 2'b00);

    assign input_axis_tready = free_now && !reset;
    assign in_hs = input_axis_tvalid && input_axis_tready;
    assign eff   = in_pkt ? mask : cfg_enable;
    assign load  = in_hs && (eff != 2'b00);

    assign output1_axis_tdata = hold_data;
    assign output1_axis_tkeep = hold_keep;
    assign output1_axis_tid   = hold_id;
    assign output1_axis_tlast = hold_last;
    assign output2_axis_tdata = hold_data;
    assign output2_axis_tkeep = hold_keep;
    assign output2_axis_tid   = hold_id;
    assign output2_axis_tlast = hold_last;

    assign busy = full || in_pkt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full   <= 1'b0;
            pend   <= 2'b00;
            mask   <= 2'b00;
            in_pkt <= 1'b0;
        end else begin
            if (load) begin
                full <= 1'b1;
                pend <= eff;
            end else if (free_now) begin
                full <= 1'b0;
                pend <= 2'b00;
            end else begin
                pend <= pend & ~hs;
            end
            if (in_hs) begin
                in_pkt <= !input_axis_tlast;
                if (!in_pkt) begin
                    mask <= cfg_enable;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_keep <= '0;
            hold_id   <= '0;
            hold_last <= 1'b0;
        end else if (load) begin
            hold_data <= input_axis_tdata;
            hold_keep <= input_axis_tkeep;
            hold_id   <= input_axis_tid;
            hold_last <= input_axis_tlast;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_count1 <= '0;
            pkt_count2 <= '0;
        end else begin
            if (hs[0] && hold_last) begin
                pkt_count1 <= pkt_count1 + CNT_W'(1);
            end
            if (hs[1] && hold_last) begin
                pkt_count2 <= pkt_count2 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_fork_ctrl.sv
// Scoreboard bench for axis_fork_ctrl: expected beats are queued per output
// at input handshake time and popped when each output handshakes.
module tb_axis_fork_ctrl;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int ID_W   = 6;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        cfg_enable = 2'b11;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [KEEP_W-1:0] in_keep = '0;
    logic [ID_W-1:0]   in_id = '0;
    logic              in_last = 1'b0;
    logic              v1, v2;
    logic              r1 = 1'b1;
    logic              r2 = 1'b1;
    logic [DATA_W-1:0] d1, d2;
    logic [KEEP_W-1:0] k1, k2;
    logic [ID_W-1:0]   id1, id2;
    logic              l1, l2;
    logic [CNT_W-1:0]  cnt1, cnt2;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int hs1_n = 0;
    int hs2_n = 0;

    beat_t q1[$];
    beat_t q2[$];
    logic       m_in_pkt = 1'b0;
    logic [1:0] m_mask = 2'b00;

    axis_fork_ctrl #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .cfg_enable(cfg_enable),
        .input_axis_tvalid(in_valid), .input_axis_tready(in_ready),
        .input_axis_tdata(in_data), .input_axis_tkeep(in_keep),
        .input_axis_tid(in_id), .input_axis_tlast(in_last),
        .output1_axis_tvalid(v1), .output1_axis_tready(r1),
        .output1_axis_tdata(d1), .output1_axis_tkeep(k1),
        .output1_axis_tid(id1), .output1_axis_tlast(l1),
        .output2_axis_tvalid(v2), .output2_axis_tready(r2),
        .output2_axis_tdata(d2), .output2_axis_tkeep(k2),
        .output2_axis_tid(id2), .output2_axis_tlast(l2),
        .pkt_count1(cnt1), .pkt_count2(cnt2), .busy(busy)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor; inputs are stable between negedge and posedge.
    always @(negedge clock) begin
        beat_t exp_b;
        beat_t got;
        logic [1:0] eff;
        if (reset) begin
            q1.delete();
            q2.delete();
            m_in_pkt = 1'b0;
            m_mask = 2'b00;
        end else begin
            if (v1 && r1) begin
                hs1_n++;
                checks++;
                got = '{data: d1, keep: k1, id: id1, last: l1};
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected got id=%h last=%b", id1, l1);
                end else begin
                    exp_b = q1.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL out1_beat got %h/%h/%b want %h/%h/%b",
                                 got.data[31:0], got.id, got.last,
                                 exp_b.data[31:0], exp_b.id, exp_b.last);
                    end
                end
            end
            if (v2 && r2) begin
                hs2_n++;
                checks++;
                got = '{data: d2, keep: k2, id: id2, last: l2};
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL out2_unexpected got id=%h last=%b", id2, l2);
                end else begin
                    exp_b = q2.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL out2_beat got %h/%h/%b want %h/%h/%b",
                                 got.data[31:0], got.id, got.last,
                                 exp_b.data[31:0], exp_b.id, exp_b.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                eff = m_in_pkt ? m_mask : cfg_enable;
                exp_b = '{data: in_data, keep: in_keep, id: in_id, last: in_last};
                if (eff[0]) q1.push_back(exp_b);
                if (eff[1]) q2.push_back(exp_b);
                if (!m_in_pkt) m_mask = cfg_enable;
                m_in_pkt = !in_last;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_beat(input int seed, input logic last, output int stalls);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = {16{32'(seed) ^ 32'h5A00_0000}};
        in_keep  = {KEEP_W{1'b1}} >> (seed % 8);
        in_id    = ID_W'(seed);
        in_last  = last;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_timeout seed=%0d ready=%b want 1", seed, in_ready);
        end
        stalls = n;
        @(posedge clock);
        #1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic check_cnts(input string name, input int w1, input int w2);
        checks++;
        if (cnt1 !== CNT_W'(w1) || cnt2 !== CNT_W'(w2)) begin
            errors++;
            $display("FAIL %s counts got %0d/%0d want %0d/%0d",
                     name, cnt1, cnt2, w1, w2);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain got q1=%0d q2=%0d want 0/0", q1.size(), q2.size());
        end
    endtask

    task automatic test_reset();
        #2;
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_v1", v1, 1'b0);
        check_bit("rst_v2", v2, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_cnts("rst", 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_bit("rst_release_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int st;
        int stall_sum;
        cfg_enable = 2'b11;
        r1 = 1'b1;
        r2 = 1'b1;
        stall_sum = 0;
        for (int i = 0; i < 8; i++) begin
            drive_beat(100 + i, i == 7, st);
            stall_sum += st;
            if (i == 0) begin
                check_bit("b2b_lat_v1", v1, 1'b1);
                check_bit("b2b_lat_v2", v2, 1'b1);
                checks++;
                if (d1 !== {16{32'(100) ^ 32'h5A00_0000}}) begin
                    errors++;
                    $display("FAIL b2b_lat_data got %h want first beat", d1[31:0]);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (stall_sum != 0) begin
            errors++;
            $display("FAIL b2b_stalls got %0d want 0", stall_sum);
        end
        // One edge after the last input beat, the last copy must be gone.
        settle(1);
        check_cnts("b2b", 1, 1);
    endtask

    task automatic test_stall();
        int st;
        int b1, b2;
        cfg_enable = 2'b11;
        r1 = 1'b1;
        r2 = 1'b0;
        b1 = hs1_n;
        b2 = hs2_n;
        drive_beat(32'hA5, 1'b1, st);
        in_valid = 1'b0;
        checks++;
        if (d1[7:0] !== 8'hA5 ^ 8'h00 || d1[31:24] !== 8'h5A) begin
            errors++;
            $display("FAIL stall_data got %h want 5a0000a5", d1[31:0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_bit("stall_v1", v1, i == 0);
            check_bit("stall_v2", v2, 1'b1);
            check_bit("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clock);
        #1;
        r2 = 1'b1;
        @(negedge clock);
        check_bit("stall_release_ready", in_ready, 1'b1);
        @(negedge clock);
        check_bit("stall_v2_drop", v2, 1'b0);
        checks++;
        if (hs1_n - b1 != 1 || hs2_n - b2 != 1) begin
            errors++;
            $display("FAIL stall_once got %0d/%0d want 1/1", hs1_n - b1, hs2_n - b2);
        end
        settle(1);
        check_cnts("stall", 2, 2);
    endtask

    task automatic test_mask_latch();
        int st;
        cfg_enable = 2'b01;
        for (int i = 0; i < 4; i++) begin
            drive_beat(200 + i, i == 3, st);
            if (i == 0) cfg_enable = 2'b11;
            check_bit("mask_v2_off", v2, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive_beat(300 + i, i == 3, st);
        end
        in_valid = 1'b0;
        settle(2);
        check_cnts("mask", 4, 3);
    endtask

    task automatic test_disabled();
        int st;
        cfg_enable = 2'b00;
        for (int i = 0; i < 3; i++) begin
            drive_beat(400 + i, i == 2, st);
            check_bit("dis_no_stall", st == 0, 1'b1);
            check_bit("dis_v1", v1, 1'b0);
            check_bit("dis_v2", v2, 1'b0);
            check_bit("dis_busy", busy, i != 2);
        end
        in_valid = 1'b0;
        settle(2);
        check_cnts("dis", 4, 3);
    endtask

    task automatic test_wrap();
        int st;
        cfg_enable = 2'b01;
        for (int i = 0; i < 11; i++) begin
            drive_beat(500 + i, 1'b1, st);
        end
        in_valid = 1'b0;
        settle(2);
        check_cnts("wrap_max", 15, 3);
        drive_beat(600, 1'b1, st);
        in_valid = 1'b0;
        settle(2);
        check_cnts("wrap_zero", 0, 3);
    endtask

    task automatic test_reset_mid();
        int st;
        cfg_enable = 2'b11;
        r1 = 1'b0;
        r2 = 1'b0;
        drive_beat(700, 1'b0, st);
        in_valid = 1'b0;
        check_bit("mid_busy_pre", busy, 1'b1);
        check_bit("mid_v1_pre", v1, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("mid_v1", v1, 1'b0);
        check_bit("mid_v2", v2, 1'b0);
        check_bit("mid_busy", busy, 1'b0);
        check_bit("mid_in_ready", in_ready, 1'b0);
        check_cnts("mid", 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_bit("mid_release_ready", in_ready, 1'b1);
        check_bit("mid_release_busy", busy, 1'b0);
        r1 = 1'b1;
        r2 = 1'b1;
        settle(2);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_mask_latch();
        test_disabled();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
